// File: rtl/bcd_operand_loader.sv
// Serial BCD front end: shifts MS-first digits into A, then B, then holds {a, b, cin} for the adder.
// Latency: out_valid rises the cycle after B's last accept; in_ready is low in HOLD, so the source holds its digit.
// Optional `BCD_CHECK_EN: non-BCD digits are stored as 0 and raise a sticky err for the operand pair.
module bcd_operand_loader #(
  parameter int DIGITS = 100
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [3:0]          in_digit,
  input  logic                in_cin,
  output logic [4*DIGITS-1:0] a,
  output logic [4*DIGITS-1:0] b,
  output logic                cin,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                err
);
  localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIGITS - 1);

  typedef enum logic [1:0] {LOAD_A, LOAD_B, HOLD} state_t;

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] cnt;
  logic          accept;
  logic          last_digit;
  logic          first_a;
  logic [3:0]    digit_st;

  assign accept     = in_valid & in_ready;
  assign last_digit = (cnt == LAST);
  assign first_a    = (state == LOAD_A) && (cnt == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= LOAD_A;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      LOAD_A:  if (accept && last_digit) state_nxt = LOAD_B;
      LOAD_B:  if (accept && last_digit) state_nxt = HOLD;
      HOLD:    if (out_ready) state_nxt = LOAD_A;
      default: state_nxt = LOAD_A;
    endcase
  end

  // Handshake outputs depend on registered state only.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      LOAD_A, LOAD_B: in_ready  = 1'b1;
      HOLD:           out_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (accept) begin
      cnt <= last_digit ? '0 : cnt + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a   <= '0;
      b   <= '0;
      cin <= 1'b0;
    end else if (accept) begin
      if (state == LOAD_A) begin
        a <= {a[4*DIGITS-5:0], digit_st};
        if (cnt == '0) cin <= in_cin;
      end else begin
        b <= {b[4*DIGITS-5:0], digit_st};
      end
    end
  end

`ifdef BCD_CHECK_EN
  logic bad_digit;

  assign bad_digit = (in_digit > 4'd9);
  assign digit_st  = bad_digit ? 4'h0 : in_digit;

  // The first A digit of a pair restarts the flag rather than or-ing into it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err <= 1'b0;
    end else if (accept) begin
      if (first_a) begin
        err <= bad_digit;
      end else if (bad_digit) begin
        err <= 1'b1;
      end
    end
  end
`else
  logic unused_first_a;

  assign unused_first_a = first_a;
  assign digit_st       = in_digit;
  assign err            = 1'b0;
`endif

endmodule
